exec_wb_stage: RTL and testbench

EXEC_WB_STAGE -- requirements
Module: exec_wb_stage

---
 rtl/exec_wb_stage.sv | 150 +++++++++++++++
 tb/tb_exec_wb_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/exec_wb_stage.sv
// rtl/exec_wb_stage.sv - three-state execute/write-back stage (IDLE->EXEC->WB)
// Optional flag_z/flag_c outputs are built when EXEC_FLAGS_EN is defined.
module exec_wb_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [2:0]       dst,
    input  logic [2:0]       src1,
    input  logic [2:0]       src2,
    input  logic             use_imm,
    input  logic [WIDTH-1:0] imm,
    output logic [2:0]       ra1,
    output logic [2:0]       ra2,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    output logic             we3,
    output logic [2:0]       wa3,
    output logic [WIDTH-1:0] wd3,
`ifdef EXEC_FLAGS_EN
    output logic             flag_z,
    output logic             flag_c,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_OR    = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_SLTU  = 3'd5;
    localparam logic [2:0] OP_PASSB = 3'd6;
    localparam logic [2:0] OP_NOP   = 3'd7;

    state_t            state_q, state_d;
    logic [2:0]        op_q, dst_q, src1_q, src2_q;
    logic              use_imm_q;
    logic [WIDTH-1:0]  imm_q;
    logic [2:0]        wa3_q;
    logic [WIDTH-1:0]  wd3_q;
    logic              accept;
    logic              load_result;

    logic [WIDTH-1:0]  opa, opb, result_d;
    logic [WIDTH:0]    sum_ext, diff_ext;

    assign accept      = (state_q == IDLE) && in_valid;
    assign load_result = (state_q == EXEC);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        we3      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = EXEC;
            end
            EXEC: state_d = WB;
            WB: begin
                we3     = (op_q != OP_NOP) && (dst_q != 3'd0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand mux and ALU; A < B unsigned is exactly the borrow of A - B.
    always_comb begin
        opa      = rd1;
        opb      = use_imm_q ? imm_q : rd2;
        sum_ext  = {1'b0, opa} + {1'b0, opb};
        diff_ext = {1'b0, opa} - {1'b0, opb};
        result_d = '0;
        case (op_q)
            OP_ADD:   result_d = sum_ext[WIDTH-1:0];
            OP_SUB:   result_d = diff_ext[WIDTH-1:0];
            OP_AND:   result_d = opa & opb;
            OP_OR:    result_d = opa | opb;
            OP_XOR:   result_d = opa ^ opb;
            OP_SLTU:  result_d = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
            OP_PASSB: result_d = opb;
            default:  result_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            dst_q     <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            wa3_q     <= '0;
            wd3_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q      <= op;
                dst_q     <= dst;
                src1_q    <= src1;
                src2_q    <= src2;
                use_imm_q <= use_imm;
                imm_q     <= imm;
            end
            // Write port registers only move at the end of EXEC, so they hold otherwise.
            if (load_result) begin
                wa3_q <= dst_q;
                wd3_q <= result_d;
            end
        end
    end

`ifdef EXEC_FLAGS_EN
    logic flag_z_q, flag_c_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (load_result && (op_q != OP_NOP)) begin
            flag_z_q <= (result_d == '0);
            flag_c_q <= (op_q == OP_ADD) ? sum_ext[WIDTH] :
                        (op_q == OP_SUB) ? diff_ext[WIDTH] : 1'b0;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
`endif

    assign ra1  = src1_q;
    assign ra2  = src2_q;
    assign wa3  = wa3_q;
    assign wd3  = wd3_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_exec_wb_stage.sv
// tb/tb_exec_wb_stage.sv - scoreboard bench for exec_wb_stage with a behavioural register-file model
module tb_exec_wb_stage;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op, dst, src1, src2;
    logic         use_imm;
    logic [W-1:0] imm;
    logic [2:0]   ra1, ra2;
    logic [W-1:0] rd1, rd2;
    logic         we3;
    logic [2:0]   wa3;
    logic [W-1:0] wd3;
    logic         busy;
`ifdef EXEC_FLAGS_EN
    logic         flag_z, flag_c;
`endif

    exec_wb_stage #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .dst      (dst),
        .src1     (src1),
        .src2     (src2),
        .use_imm  (use_imm),
        .imm      (imm),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .we3      (we3),
        .wa3      (wa3),
        .wd3      (wd3),
`ifdef EXEC_FLAGS_EN
        .flag_z   (flag_z),
        .flag_c   (flag_c),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    logic [W-1:0] rf [8];
    logic         init_rf;

    always @(posedge clk) begin
        if (init_rf) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (we3) begin
            rf[wa3] <= wd3;
        end
    end

    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    int mrf [8];
    logic [10:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;
    int exp_fz, exp_fc;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (!rst && we3) begin
            logic [10:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_we3: got wa3=%0h wd3=%0h expected no write", wa3, wd3);
            end else begin
                e = exp_q.pop_front();
                if ({wa3, wd3} != e) begin
                    n_errors++;
                    $display("FAIL write: got wa3=%0h wd3=%0h expected wa3=%0h wd3=%0h",
                             wa3, wd3, e[10:8], e[7:0]);
                end
            end
        end
    end

    function automatic int model_exec(input int o, input int a, input int b);
        int m;
        m = (1 << W) - 1;
        exp_fc = 0;
        case (o)
            0: begin model_exec = (a + b) & m; exp_fc = (a + b > m) ? 1 : 0; end
            1: begin model_exec = (a - b) & m; exp_fc = (a < b) ? 1 : 0; end
            2: model_exec = a & b;
            3: model_exec = a | b;
            4: model_exec = a ^ b;
            5: model_exec = (a < b) ? 1 : 0;
            6: model_exec = b;
            default: model_exec = 0;
        endcase
        exp_fz = (model_exec == 0) ? 1 : 0;
    endfunction

    task automatic issue(input int o, input int d, input int s1, input int s2,
                         input int ui, input int im, input bit abort);
        int waitc, a, b, res;
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (in_ready !== 1'b1) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        op = 3'(o); dst = 3'(d); src1 = 3'(s1); src2 = 3'(s2);
        use_imm = ui[0]; imm = W'(im);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom); dst = 3'($urandom); src1 = 3'($urandom); imm = W'($urandom);
        a   = mrf[s1];
        b   = (ui != 0) ? im : mrf[s2];
        res = model_exec(o, a, b);
        chk("rdy_exec", int'(in_ready), 0);
        chk("busy_exec", int'(busy), 1);
        if (abort) begin
            rst = 1'b1; #1;
            chk("rdy_in_rst", int'(in_ready), 1);
            chk("busy_in_rst", int'(busy), 0);
            chk("we3_in_rst", int'(we3), 0);
            @(posedge clk); #1;
            chk("we3_in_rst2", int'(we3), 0);
            @(negedge clk);
            rst = 1'b0;
`ifdef EXEC_FLAGS_EN
            exp_fz = 0; exp_fc = 0;
            chk("flag_z_rst", int'(flag_z), 0);
            chk("flag_c_rst", int'(flag_c), 0);
`endif
            return;
        end
        if (o != 7 && d != 0) begin
            exp_q.push_back({3'(d), W'(res)});
            mrf[d] = res;
        end
        @(posedge clk); #1;
        chk("rdy_wb", int'(in_ready), 0);
        chk("busy_wb", int'(busy), 1);
        @(posedge clk); #1;
        chk("rdy_idle", int'(in_ready), 1);
        chk("busy_idle", int'(busy), 0);
`ifdef EXEC_FLAGS_EN
        if (o != 7) begin
            chk("flag_z", int'(flag_z), exp_fz);
            chk("flag_c", int'(flag_c), exp_fc);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mrf[i] = 0;
        rst = 1'b1; in_valid = 1'b0; init_rf = 1'b1;
        op = '0; dst = '0; src1 = '0; src2 = '0; use_imm = 1'b0; imm = '0;
        @(posedge clk); #1;
        init_rf = 1'b0;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_we3", int'(we3), 0);
        chk("rst_wa3", int'(wa3), 0);
        chk("rst_wd3", int'(wd3), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);

        issue(6, 1, 0, 0, 1, 8'h2A, 1'b0);
        chk("x1_load_imm", int'(rf[1]), 8'h2A);

        issue(6, 1, 0, 0, 1, 8'hFF, 1'b0);
        issue(6, 2, 0, 0, 1, 8'h01, 1'b0);
        issue(0, 3, 1, 2, 0, 0, 1'b0);
        chk("wrap_add", int'(rf[3]), 0);

        issue(6, 1, 0, 0, 1, 8'h05, 1'b0);
        issue(6, 2, 0, 0, 1, 8'h03, 1'b0);
        issue(0, 3, 1, 2, 0, 0, 1'b0);
        issue(1, 4, 3, 1, 0, 0, 1'b0);
        chk("dep_r3", int'(rf[3]), 8'h08);
        chk("dep_r4", int'(rf[4]), 8'h03);

        issue(4, 0, 1, 2, 0, 0, 1'b0);
        issue(7, 5, 1, 2, 0, 0, 1'b0);
        chk("nop_r5", int'(rf[5]), 0);

        issue(0, 6, 1, 2, 0, 0, 1'b1);
        chk("abort_r6", int'(rf[6]), 0);

        issue(6, 1, 0, 0, 1, 8'h10, 1'b0);
        issue(6, 2, 0, 0, 1, 8'h80, 1'b0);
        issue(5, 7, 1, 2, 0, 0, 1'b0);
        chk("sltu_lt", int'(rf[7]), 1);
        issue(5, 7, 2, 1, 0, 0, 1'b0);
        chk("sltu_ge", int'(rf[7]), 0);

        for (int n = 0; n < 80; n++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
            issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        for (int i = 0; i < 8; i++) chk($sformatf("rf_final_%0d", i), int'(rf[i]), mrf[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
